// File: rtl/sf_serial_addsub.sv
// Purpose : beat-serial modular A+B / A-B over WORD_W bits, DW bits per beat, LS beat first.
// Latency : 1 cycle from an in_valid beat to its out_valid result beat; all outputs registered.
// Backpr. : none; the consumer must take every out_valid beat; flush aborts the word in progress.
//
// Ports:
//   clk, reset_n       rising-edge clock, asynchronous active-low reset
//   flush              synchronous abort; beat counter and carry return to 0, wins over in_valid
//   in_valid/in_a      A operand beat strobe and data
//   in_b               B operand beat, pushed into a B_DELAY-deep alignment line every cycle
//   in_sub             0 = add, 1 = subtract; only looked at on beat 0 of a word
//   out_valid/out_data result beat strobe and data
//   out_first/last     result beat is beat 0 / beat BEATS-1 of its word
//   out_carry          word carry-out (add) or not-borrow (sub); meaningful with out_last
// WORD_W must be an integer multiple of DW.

module sf_serial_addsub #(
    parameter int DW      = 8,
    parameter int WORD_W  = 32,
    parameter int B_DELAY = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_sub,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_first,
    output logic          out_last,
    output logic          out_carry
);

    localparam int BEATS = WORD_W / DW;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // B operand after alignment with the (late) A stream.
    logic [DW-1:0] b_op;

    generate
        if (B_DELAY == 0) begin : g_no_dly
            assign b_op = in_b;
        end else begin : g_dly
            logic [B_DELAY-1:0][DW-1:0] dly_q;
            logic [B_DELAY-1:0][DW-1:0] dly_d;

            // Shifts every cycle, independent of in_valid and flush.
            always_comb begin
                dly_d    = '0;
                dly_d[0] = in_b;
                for (int i = 1; i < B_DELAY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign b_op = dly_q[B_DELAY-1];
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             out_carry_q, out_carry_d;

    logic             first_beat;
    logic             last_beat;
    logic             mode_eff;
    logic             cin;
    logic [DW-1:0]    b_x;
    logic [DW:0]      sum_full;

    always_comb begin
        first_beat = (cnt_q == '0);
        last_beat  = (cnt_q == LAST_CNT);
        // Beat 0 takes the mode straight from in_sub and seeds the carry with it,
        // so a new word never sees the previous word's carry (A + ~B + 1 for sub).
        mode_eff   = first_beat ? in_sub : mode_q;
        cin        = first_beat ? in_sub : carry_q;
        b_x        = mode_eff ? ~b_op : b_op;
        sum_full   = {1'b0, in_a} + {1'b0, b_x} + (DW+1)'(cin);

        cnt_d       = cnt_q;
        carry_d     = carry_q;
        mode_d      = mode_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_carry_d = out_carry_q;

        if (flush) begin
            cnt_d   = '0;
            carry_d = 1'b0;
        end else if (in_valid) begin
            cnt_d       = last_beat ? '0 : cnt_q + CNT_W'(1);
            carry_d     = sum_full[DW];
            mode_d      = mode_eff;
            out_valid_d = 1'b1;
            out_data_d  = sum_full[DW-1:0];
            out_first_d = first_beat;
            out_last_d  = last_beat;
            out_carry_d = sum_full[DW];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            mode_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_carry_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_carry = out_carry_q;

endmodule

// File: doc/sf_serial_addsub.md
Name: sf_serial_addsub

Overview:
- Parametrised beat-serial modular adder/subtractor for the SEED round and key-schedule datapath.
- Adds or subtracts two WORD_W-bit words presented DW bits per beat, least-significant beat first, carrying/borrowing between beats.
- A configurable internal delay line aligns the B operand with a late-arriving A stream, such as the output of a G-function pipeline.
- Generalises the fixed 8-bit, add-only, counter-scheduled F-function adder: handshake-driven, width-parametric, with subtract mode and word-level carry out.

Parameters:
- DW, 8, beat width in bits; WORD_W must be an integer multiple of DW.
- WORD_W, 32, modular word width; arithmetic is mod 2^WORD_W.
- B_DELAY, 4, cycles in_b is delayed internally before use; 0 means no delay.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the word in progress.
- in_valid  input  1  A beat present this cycle.
- in_a  input  DW  A operand beat.
- in_b  input  DW  B operand beat, sampled every cycle into the delay line.
- in_sub  input  1  0 = A+B, 1 = A-B; sampled on the first beat of a word only.
- out_valid  output  1  result beat valid.
- out_data  output  DW  result beat.
- out_first  output  1  result beat is beat 0 of a word.
- out_last  output  1  result beat is beat BEATS-1 of a word.
- out_carry  output  1  word carry-out (add) or not-borrow (sub); meaningful only when out_last=1.

Behaviour:
- BEATS = WORD_W/DW. Beat counter runs 0..BEATS-1 and advances only on cycles with in_valid=1. It wraps to 0 after BEATS-1.
- B alignment: operand b = in_b sampled B_DELAY cycles earlier; the delay line shifts every cycle regardless of in_valid. With B_DELAY=0, b = in_b of the same cycle.
- Beat 0: mode latches from in_sub. Carry-in = latched mode (1 for sub, giving the two's complement A + ~B + 1).
- Beats 1..BEATS-1: carry-in = carry register. in_sub is ignored; the mode stays latched until the next beat 0.
- Per valid beat: {cout, sum} = a + (mode ? ~b : b) + cin, computed over DW+1 bits. The carry register loads cout.
- Cycles with in_valid=0 hold the carry register, beat counter and mode. Gaps of any length between beats are legal.
- Latency is 1 cycle, with all outputs registered:
  - out_valid = in_valid delayed by one cycle; out_data = sum.
  - out_first = (count==0); out_last = (count==BEATS-1); out_carry = cout.
- On idle cycles out_valid=0. out_data, out_first, out_last and out_carry hold their last values and must be ignored.
- Back-to-back words: beat 0 of the next word never uses the carry of the previous word.
- flush=1:
  - Next cycle: beat counter=0, carry register=0, out_valid=0.
  - A beat presented with flush is discarded. The delay line is unaffected.
  - flush has priority over in_valid.
- reset_n=0, asynchronous and at any time, including mid-word:
  - All registers cleared: counter, carry, mode, delay line.
  - Outputs: out_valid=0, out_data=0, out_first=0, out_last=0, out_carry=0.
  - The first valid beat after deassertion is beat 0.
- BEATS=1 (DW=WORD_W) is legal: every valid beat is both first and last, and carry-in is always the mode bit.
- No backpressure; the consumer must accept every out_valid beat.

Test Plan:
- Add wrap: DW=8, B_DELAY=0, in_sub=0, A=0xFFFFFFFF, B=0x00000001 sent LS-beat first on 4 consecutive cycles. Required: out_data 00,00,00,00; out_first on beat 0; out_last on beat 3; out_carry=1.
- Subtract borrow: A=0x00000000, B=0x00000001, in_sub=1. Required: FF,FF,FF,FF with out_carry=0. Then A=0x12345678, B=0x02040608, sub. Required: 78-08=70, 56-06=50, 34-04=30, 12-02=10 (0x10305070), out_carry=1.
- Gaps and mode hold: the add-wrap word with 3 idle cycles between each beat, and in_sub toggled on the idle and non-first cycles. Required: identical result to the first scenario, with out_valid only on the 4 beat cycles.
- Alignment: B_DELAY=4, B beats driven 4 cycles before the matching A beats, with other values on in_b in between. Required: A=0x89ABCDEF + B=0x76543211 = 0x00000000 with out_carry=1.
- Back-to-back: add-wrap word immediately followed by 0x00000001+0x00000001. Required: second word = 02,00,00,00 with out_carry=0 (no carry leakage between words).
- Abort: flush on beat 2 of a word, then a fresh word 0x00000003+0x00000004; separately, reset_n pulsed low mid-word. Required: fresh word = 07,00,00,00 starting at out_first; outputs read 0 during reset.
